regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port register file. It is the next-generation general-purpose register storage for the MIPS datapath.
- Independent read and write ports: reads and writes can happen in the same cycle.
- Write-to-read bypass.
- Hardwired zero register.
- Per-register busy scoreboard that the issue stage uses for RAW hazard detection.
It sits between decode/issue (read ports, busy set) and writeback (two write ports).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
NRD, 3, number of read ports
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and busy sets
BYPASS, 1, 1 = same-cycle write data is forwarded to reads of the same address

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  synchronous active-low reset
re  in  NRD  per-port read enable
raddr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rdata  out  NRD*DATA_W  registered read data; port k uses bits [k*DATA_W +: DATA_W]
rvalid  out  NRD  high one cycle after re[k] was sampled high
rbusy  out  NRD  registered scoreboard bit of the register read on port k
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
busy_set  in  1  mark register busy_addr as having an in-flight producer
busy_addr  in  ADDR_W  scoreboard address to set
busy_any  out  1  OR of all scoreboard bits, registered

Behaviour:
- Clock is clk. Reset is synchronous and active-low on reset_n, sampled on the rising edge of clk.
- Reset: all registers, rdata, rvalid, rbusy, scoreboard and busy_any go to 0 at the edge where reset_n=0. Writes, reads and busy_set presented in that cycle are discarded. Asserting reset in the middle of a sequence has the same effect: the next edge clears everything.
- Read latency is one cycle.
  - re[k]=1 at edge N: rdata[k] and rbusy[k] update and rvalid[k]=1 after edge N.
  - re[k]=0: rdata[k] and rbusy[k] hold their previous values and rvalid[k]=0.
- Writes commit at the edge when weX=1.
  - we0 and we1 to the same address in the same cycle: port 1 wins.
  - Different addresses: both commit.
- Bypass (BYPASS=1): a read in the same cycle as a write to the same address returns that cycle's wdata; port 1 data takes priority over port 0.
- No bypass (BYPASS=0): a same-cycle read returns the pre-write value.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
  - busy_set to address 0 is ignored, so rbusy for address 0 is always 0.
- Scoreboard, one bit per register:
  - busy_set sets bit[busy_addr] at the edge.
  - A commit on either write port clears bit[waddrX].
  - busy_set and a write to the same address in the same cycle: set wins, because a newer producer has been issued.
- rbusy[k] = bit[raddr[k]] before the edge, with same-cycle write clears applied and same-cycle sets ignored. This keeps rbusy consistent with bypassed rdata.
- busy_any is registered and reflects the scoreboard after the edge.
- Read ports are fully independent: any number of ports may read the same address.

Test Plan:
- Reset, then re=3'b111 with raddr = 1, 2, 3 -> rdata all 0, rvalid=3'b111 one cycle later, rbusy=0, busy_any=0.
- we0 writes waddr0=5 with 0xDEADBEEF while port 0 reads address 5 in the same cycle -> BYPASS=1: rdata0=0xDEADBEEF next cycle; BYPASS=0: rdata0=0, and 0xDEADBEEF on a re-read.
- we0 and we1 both write address 7, with 0x11 and 0x22 respectively -> a later read of 7 returns 0x22. A write to address 0 with 0xFFFFFFFF -> a read of 0 returns 0.
- busy_set address 9 -> busy_any=1 and a read of 9 gives rbusy=1. Then we1 writes 9 while port 2 reads 9 in the same cycle -> rbusy2=0, rdata2 = the written data, busy_any=0.
- busy_set address 4 in the same cycle as we0 to address 4 -> bit stays set; a read of 4 returns rbusy=1.
- Write 0xA5 to address 3 and set busy on address 6, then hold reset_n=0 for one edge during an active read -> all outputs 0, the read of 3 returns 0, rvalid=0, busy_any=0.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass, zero register and busy scoreboard
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rvalid,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic                  busy_set,
    input  logic [ADDR_W-1:0]     busy_addr,
    output logic                  busy_any
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  sb_q;
    logic [DEPTH-1:0]  sb_next;
    logic              busy_any_q;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              set_ok;

    // Register 0 is filtered here so every consumer sees the same commit decision.
    assign wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
    assign set_ok = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

    // Clears first, then the set, so a newly issued producer outranks a retiring one.
    always_comb begin
        sb_next = sb_q;
        if (wr0_ok) begin
            sb_next[waddr0] = 1'b0;
        end
        if (wr1_ok) begin
            sb_next[waddr1] = 1'b0;
        end
        if (set_ok) begin
            sb_next[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sb_q       <= '0;
            busy_any_q <= 1'b0;
        end else begin
            sb_q       <= sb_next;
            busy_any_q <= |sb_next;
        end
    end

    assign busy_any = busy_any_q;

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1_ok) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_val;
        logic              rb_val;
        logic [DATA_W-1:0] rd_q;
        logic              rv_q;
        logic              rb_q;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_val = mem[ra];
            if (BYPASS != 0) begin
                if (wr1_ok && (waddr1 == ra)) begin
                    rd_val = wdata1;
                end else if (wr0_ok && (waddr0 == ra)) begin
                    rd_val = wdata0;
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_val = '0;
            end
            // Same-cycle clears apply, same-cycle sets do not: matches the bypassed data.
            rb_val = sb_q[ra] && !((wr0_ok && (waddr0 == ra)) || (wr1_ok && (waddr1 == ra)));
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rd_q <= '0;
                rv_q <= 1'b0;
                rb_q <= 1'b0;
            end else begin
                rv_q <= re[k];
                if (re[k]) begin
                    rd_q <= rd_val;
                    rb_q <= rb_val;
                end
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_q;
        assign rvalid[k]                 = rv_q;
        assign rbusy[k]                  = rb_q;
    end

endmodule
